// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: timer states, minimum legal
// configuration, and sample index encodings.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } rx_state_t;

  localparam int unsigned MIN_PRESCALE   = 4;
  localparam int unsigned MIN_FRAME_BITS = 2;

  localparam logic [1:0] SMP_EARLY = 2'd0;
  localparam logic [1:0] SMP_MID   = 2'd1;
  localparam logic [1:0] SMP_LATE  = 2'd2;

endpackage

// File: rtl/uart_rx_sample_decode.sv
// Combinational decode of the edge position within a bit into the three
// mid-bit sample strobes and the last-edge flag.
module uart_rx_sample_decode
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sample_en,
  output logic [1:0]            sample_idx,
  output logic                  last_edge
);

  localparam int W = PRESCALE_W + 1;

  logic [W-1:0] p_ext;
  logic [W-1:0] e_ext;
  logic [W-1:0] mid;
  logic [W-1:0] last_pos;

  // One extra bit keeps P-1, M+1 and edge+1 from wrapping.
  assign p_ext    = {1'b0, prescale};
  assign e_ext    = {1'b0, edge_cnt};
  assign mid      = p_ext >> 1;
  assign last_pos = p_ext - W'(1);

  // edge+1 == M stands in for edge == M-1 so that a zero M cannot underflow.
  always_comb begin
    sample_en  = 1'b0;
    sample_idx = SMP_EARLY;
    if (e_ext + W'(1) == mid) begin
      sample_en  = 1'b1;
      sample_idx = SMP_EARLY;
    end else if (e_ext == mid) begin
      sample_en  = 1'b1;
      sample_idx = SMP_MID;
    end else if (e_ext == mid + W'(1)) begin
      sample_en  = 1'b1;
      sample_idx = SMP_LATE;
    end
  end

  assign last_edge = (e_ext == last_pos);

endmodule

// File: rtl/uart_rx_bit_timer.sv
// UART receive bit timer: counts oversampling edges and bits over one frame
// and emits sample, bit-done and frame-done strobes from registered state.
module uart_rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [CNT_W-1:0]      frame_bits,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [CNT_W-1:0]      bit_cnt,
  output logic                  sample_en,
  output logic [1:0]            sample_idx,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  cfg_err
);

  localparam int PW1 = PRESCALE_W + 1;
  localparam int CW1 = CNT_W + 1;
  localparam logic [PW1-1:0] MIN_P = PW1'(MIN_PRESCALE);
  localparam logic [CW1-1:0] MIN_F = CW1'(MIN_FRAME_BITS);

  rx_state_t             state_reg, state_next;
  logic [PRESCALE_W-1:0] p_reg, p_next;
  logic [CNT_W-1:0]      f_reg, f_next;
  logic [PRESCALE_W-1:0] edge_reg, edge_next;
  logic [CNT_W-1:0]      bit_reg, bit_next;

  logic       dec_sample_en;
  logic [1:0] dec_sample_idx;
  logic       dec_last_edge;
  logic       run;
  logic       last_bit;
  logic       cfg_ok;

  uart_rx_sample_decode #(
    .PRESCALE_W (PRESCALE_W)
  ) u_decode (
    .prescale   (p_reg),
    .edge_cnt   (edge_reg),
    .sample_en  (dec_sample_en),
    .sample_idx (dec_sample_idx),
    .last_edge  (dec_last_edge)
  );

  assign run      = (state_reg == RUN);
  assign last_bit = ({1'b0, bit_reg} == ({1'b0, f_reg} - CW1'(1)));
  assign cfg_ok   = ({1'b0, prescale} >= MIN_P) && ({1'b0, frame_bits} >= MIN_F);

  // Strobes depend only on registered state, never on the inputs.
  assign sample_en  = run & dec_sample_en;
  assign sample_idx = run ? dec_sample_idx : SMP_EARLY;
  assign bit_done   = run & dec_last_edge;
  assign frame_done = bit_done & last_bit;
  assign cfg_err    = (state_reg == ERR);
  assign edge_cnt   = edge_reg;
  assign bit_cnt    = bit_reg;

  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    f_next     = f_reg;
    edge_next  = '0;
    bit_next   = '0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cfg_ok) begin
            state_next = RUN;
            p_next     = prescale;
            f_next     = frame_bits;
          end else begin
            state_next = ERR;
          end
        end
        RUN: begin
          if (frame_done) begin
            state_next = DONE;
          end else if (bit_done) begin
            bit_next = bit_reg + CNT_W'(1);
          end else begin
            edge_next = edge_reg + PRESCALE_W'(1);
            bit_next  = bit_reg;
          end
        end
        DONE:    state_next = DONE;
        ERR:     state_next = ERR;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      p_reg     <= '0;
      f_reg     <= '0;
      edge_reg  <= '0;
      bit_reg   <= '0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      f_reg     <= f_next;
      edge_reg  <= edge_next;
      bit_reg   <= bit_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Directed bench for uart_rx_bit_timer: frame timing, sample placement,
// latch-on-start, abort, configuration errors and asynchronous reset.
module tb_uart_rx_bit_timer;
  import uart_rx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] prescale = '0;
  logic [3:0] frame_bits = '0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_en;
  logic [1:0] sample_idx;
  logic       bit_done;
  logic       frame_done;
  logic       cfg_err;

  int n_vec = 0;
  int n_bad = 0;

  uart_rx_bit_timer #(
    .PRESCALE_W (6),
    .CNT_W      (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .prescale   (prescale),
    .frame_bits (frame_bits),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .sample_en  (sample_en),
    .sample_idx (sample_idx),
    .bit_done   (bit_done),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Everything except cfg_err must read zero.
  task automatic check_quiet(input string tag);
    check({tag, ".edge"},   int'(edge_cnt),   0);
    check({tag, ".bit"},    int'(bit_cnt),    0);
    check({tag, ".smp_en"}, int'(sample_en),  0);
    check({tag, ".smp_ix"}, int'(sample_idx), 0);
    check({tag, ".bdone"},  int'(bit_done),   0);
    check({tag, ".fdone"},  int'(frame_done), 0);
  endtask

  // Raise enable with (p,f) and walk the frame cycle by cycle. done_cyc is
  // the hand-computed frame_done cycle (F*P); abort_at drops enable in that
  // cycle; chg_at rewrites prescale to chg_val in that cycle.
  task automatic run_frame(input int p, input int f, input int mid, input int done_cyc,
                           input int abort_at, input int chg_at, input int chg_val);
    int bd;
    bd = 0;
    prescale   = 6'(p);
    frame_bits = 4'(f);
    enable     = 1'b1;
    check_quiet("c0");
    check("c0.cfg_err", int'(cfg_err), 0);
    for (int c = 1; c <= done_cyc; c++) begin
      int e;
      int b;
      bit in_win;
      step();
      e      = (c - 1) % p;
      b      = (c - 1) / p;
      in_win = (e >= mid - 1) && (e <= mid + 1);
      check("edge_cnt",   int'(edge_cnt),   e);
      check("bit_cnt",    int'(bit_cnt),    b);
      check("sample_en",  int'(sample_en),  int'(in_win));
      check("sample_idx", int'(sample_idx), in_win ? e - (mid - 1) : 0);
      check("bit_done",   int'(bit_done),   int'(e == p - 1));
      check("frame_done", int'(frame_done), int'(c == done_cyc));
      check("cfg_err",    int'(cfg_err),    0);
      bd += int'(bit_done);
      if (c == chg_at) prescale = 6'(chg_val);
      if (c == abort_at) begin
        enable = 1'b0;
        step();
        check_quiet("abort");
        check("abort.cfg_err", int'(cfg_err), 0);
        $display("frame P=%0d F=%0d aborted in cycle %0d", p, f, c);
        return;
      end
    end
    check("n_bit_done", bd, f);
    for (int k = 0; k < 4; k++) begin
      step();
      check_quiet("done_hold");
    end
    enable = 1'b0;
    step();
    check_quiet("idle");
    $display("frame P=%0d F=%0d done in cycle %0d, %0d bit_done pulses", p, f, done_cyc, bd);
  endtask

  task automatic cfg_case(input int p, input int f);
    prescale   = 6'(p);
    frame_bits = 4'(f);
    enable     = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("err.cfg_err", int'(cfg_err), 1);
      check_quiet("err");
    end
    enable = 1'b0;
    step();
    check("err.clear", int'(cfg_err), 0);
    $display("config P=%0d F=%0d rejected", p, f);
  endtask

  initial begin
    step();
    check_quiet("reset");
    check("reset.cfg_err", int'(cfg_err), 0);
    #2 RST = 1'b1;
    step();
    check_quiet("post_reset");

    run_frame(8, 10, 4, 80, 0, 0, 0);
    run_frame(9, 2, 4, 18, 0, 0, 0);
    run_frame(4, 2, 2, 8, 0, 0, 0);
    run_frame(8, 3, 4, 24, 0, 5, 16);
    run_frame(16, 2, 8, 32, 0, 0, 0);
    run_frame(8, 10, 4, 80, 31, 0, 0);
    run_frame(8, 2, 4, 16, 0, 0, 0);

    cfg_case(3, 10);
    cfg_case(8, 1);

    // Asynchronous reset while a sample strobe is active.
    prescale   = 6'd8;
    frame_bits = 4'd10;
    enable     = 1'b1;
    for (int c = 1; c <= 13; c++) step();
    check("pre_rst.smp_en", int'(sample_en), 1);
    check("pre_rst.edge",   int'(edge_cnt),  4);
    #2 RST = 1'b0;
    #1;
    check_quiet("async_rst");
    check("async_rst.cfg_err", int'(cfg_err), 0);
    enable = 1'b0;
    #2 RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_quiet("rst_idle");
    end
    $display("async reset mid-frame handled");
    run_frame(4, 2, 2, 8, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_timer.md
# uart_rx_bit_timer

Parametrised bit-timing engine for the UART receiver, the successor to the fixed-width edge/bit counter. It counts oversampling edges and bits across one complete frame and produces three mid-bit sample strobes per bit, plus bit-done and frame-done pulses. It also checks the configuration. It sits between the RX FSM, which drives `enable`, and the data sampler and deserializer, which consume `sample_en`, `bit_done` and `frame_done`.

## Interface
- `PRESCALE_W`, default 6: width of `prescale` and `edge_cnt`.
- `CNT_W`, default 4: width of `frame_bits` and `bit_cnt`.
- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run request from the RX FSM; low means abort/idle.
- `prescale`  in  PRESCALE_W  oversampling edges per bit (P); latched on start.
- `frame_bits`  in  CNT_W  total bits per frame: start + data + parity + stop (F); latched on start.
- `edge_cnt`  out  PRESCALE_W  edge position within the current bit, 0..P-1.
- `bit_cnt`  out  CNT_W  bit index within the frame, 0..F-1.
- `sample_en`  out  1  high on the three mid-bit sample edges.
- `sample_idx`  out  2  which sample this is: 0, 1 or 2. Valid only with `sample_en`; 0 otherwise.
- `bit_done`  out  1  one-cycle pulse on the last edge of each bit.
- `frame_done`  out  1  one-cycle pulse on the last edge of bit F-1.
- `cfg_err`  out  1  latched error for an illegal P or F.

## Operation
- States:
  - IDLE: counters 0.
  - RUN: counting.
  - DONE: frame finished; counters 0.
  - ERR: bad configuration; counters 0.
- Transitions:
  - IDLE→RUN when `enable`=1 and the configuration is legal. P and F are latched in that same cycle.
  - IDLE→ERR when `enable`=1 and P<4 or F<2.
  - RUN→DONE on `frame_done`.
  - Any state→IDLE when `enable`=0. This has priority over every other event, and counters clear on the next edge.
  - DONE and ERR hold until `enable`=0. There is no auto-restart; the FSM must drop `enable` for at least 1 cycle.
- In RUN, every cycle:
  - If `edge_cnt`==P-1: `edge_cnt`←0 and `bit_cnt`←`bit_cnt`+1.
  - Otherwise: `edge_cnt`←`edge_cnt`+1.
- Mid point is M = P>>1, so odd P rounds down.
- `sample_en` = RUN and `edge_cnt` ∈ {M-1, M, M+1}. `sample_idx` = `edge_cnt`-(M-1).
- `bit_done` = RUN and `edge_cnt`==P-1.
- `frame_done` = `bit_done` and `bit_cnt`==F-1.
- `cfg_err` = 1 exactly while in ERR.
- Changes to `prescale` or `frame_bits` after the start cycle are ignored until the next IDLE→RUN.
- Width rules:
  - Compare against P-1 and F-1 computed in PRESCALE_W+1 and CNT_W+1 bits, so there is no wrap.
  - `edge_cnt` never exceeds P-1, and `bit_cnt` never exceeds F-1.

## Timing
- Reset: state IDLE; `edge_cnt`, `bit_cnt`, `sample_en`, `sample_idx`, `bit_done`, `frame_done` and `cfg_err` all 0.
- Counters and state are registered. The strobes are combinational decodes of registered state only, with no input-to-output path.
- Start latency: `enable` rises in cycle 0 → RUN with `edge_cnt`=0 in cycle 1.
- Bit k ends (`bit_done`) in cycle 1+(k+1)·P-1.
- `frame_done` falls in cycle F·P. All counters read 0 and DONE is entered in cycle F·P+1.
- `enable` dropping mid-frame in cycle t: counters are 0 and IDLE is entered in cycle t+1. No `bit_done` or `frame_done` is emitted in cycle t unless it was already decoded from registered state.
- Asynchronous reset mid-frame: all outputs go to 0 immediately.

## Structure
- Shared package `uart_rx_pkg`:
  - State enum: IDLE, RUN, DONE, ERR.
  - `MIN_PRESCALE`=4 and `MIN_FRAME_BITS`=2.
  - Sample index constants `SMP_EARLY`=0, `SMP_MID`=1, `SMP_LATE`=2.
- Sub-module `uart_rx_sample_decode`: combinational. Inputs: latched P and `edge_cnt`. Outputs: `sample_en`, `sample_idx` and the last-edge flag.
- Top level holds the FSM, the configuration latches and both counters.

## Test plan
- P=8, F=10, `enable` held high:
  - `sample_en` on `edge_cnt` 3, 4, 5 with `sample_idx` 0, 1, 2 on every bit.
  - 10 `bit_done` pulses, 8 cycles apart.
  - `frame_done` in cycle 80; DONE with counters 0 thereafter, with no restart.
- P=9, F=2: M=4, samples on `edge_cnt` 3, 4, 5; `frame_done` in cycle 18.
- `prescale` changed from 8 to 16 in cycle 5 of a run: timing stays at P=8 for the whole frame; the new value takes effect only after an `enable` low→high.
- `enable` dropped at `bit_cnt`=3, `edge_cnt`=6: next cycle IDLE with all outputs 0; re-raise → clean restart from bit 0.
- P=3 or F=1 with `enable`=1: `cfg_err`=1 from cycle 1, counters stay 0, no strobes; `cfg_err` clears the cycle after `enable`=0.
- Asynchronous `RST` low mid-frame: all outputs 0 without a clock edge; after release, IDLE until `enable` rises.
